// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execute stage that follows the ALU control decoder. Logic and arithmetic ops
//   complete in one clock. Shift ops (SLL/SRL/SRA) run iteratively, one bit per
//   clock. Valid/ready handshakes on both sides let a running shift stall the
//   upstream pipeline, and let a slow consumer hold the result.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake; inputs are sampled only on accept
//   alu_control[3:0]    op code from the decoder
//   operand_a/operand_b operands (operand_a is the value shifted by shift ops)
//   shamt[SHAMT_W-1:0]  shift amount, used by shift ops only
//   out_valid/out_ready result handshake
//   result, zero, overflow, illegal_op   registered result and flags
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               zero_reg, zero_next;
    logic               overflow_reg, overflow_next;
    logic               illegal_reg, illegal_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic               left_reg, left_next;
    logic               arith_reg, arith_next;

    logic               accept;
    logic               is_shift;
    logic               start_shift;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;
    logic [WIDTH-1:0]   shl_step;
    logic [WIDTH-1:0]   shr_step;
    logic [WIDTH-1:0]   shift_step;
    logic               fill_bit;

    assign in_ready    = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    assign accept      = in_valid && in_ready;
    assign is_shift    = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                         (alu_control == OP_SRA);
    // A zero-length shift completes like any single-cycle op.
    assign start_shift = is_shift && (shamt != '0);

    assign sum  = operand_a + operand_b;
    assign diff = operand_a - operand_b;

    // One-bit shift network for the iterative shifter. Right shifts fill the
    // MSB with the latched sign for SRA and with zero for SRL.
    assign fill_bit = arith_reg & shift_reg[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl_step[gi] = 1'b0;
            end else begin : g_lmid
                assign shl_step[gi] = shift_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign shr_step[gi] = fill_bit;
            end else begin : g_rmid
                assign shr_step[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign shift_step = left_reg ? shl_step : shr_step;

    // Single-cycle result. Shift codes land here only when shamt==0, in which
    // case operand_a passes through unchanged.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_control)
            OP_AND: alu_res = operand_a & operand_b;
            OP_OR:  alu_res = operand_a | operand_b;
            OP_XOR: alu_res = operand_a ^ operand_b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            // Direct signed compare, so it stays correct when a-b overflows.
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                               ($signed(operand_a) < $signed(operand_b))};
            OP_SLL, OP_SRL, OP_SRA: alu_res = operand_a;
            default: alu_ill = 1'b1;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            shift_reg     <= '0;
            count_reg     <= '0;
            left_reg      <= 1'b0;
            arith_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            overflow_reg  <= overflow_next;
            illegal_reg   <= illegal_next;
            shift_reg     <= shift_next;
            count_reg     <= count_next;
            left_reg      <= left_next;
            arith_reg     <= arith_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept && start_shift) state_next = S_SHIFT;
            S_SHIFT: if (count_reg == SHAMT_W'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output / datapath next values. Result and flags change only on an
    // accept or at shift completion, so they hold while out_valid && !out_ready.
    always_comb begin
        out_valid_next = out_valid_reg && !out_ready;
        result_next    = result_reg;
        zero_next      = zero_reg;
        overflow_next  = overflow_reg;
        illegal_next   = illegal_reg;
        shift_next     = shift_reg;
        count_next     = count_reg;
        left_next      = left_reg;
        arith_next     = arith_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (start_shift) begin
                        shift_next     = operand_a;
                        count_next     = shamt;
                        left_next      = (alu_control == OP_SLL);
                        arith_next     = (alu_control == OP_SRA);
                        out_valid_next = 1'b0;
                    end else begin
                        result_next    = alu_res;
                        zero_next      = (alu_res == '0);
                        overflow_next  = alu_ovf;
                        illegal_next   = alu_ill;
                        out_valid_next = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                shift_next = shift_step;
                count_next = count_reg - SHAMT_W'(1);
                if (count_reg == SHAMT_W'(1)) begin
                    result_next    = shift_step;
                    zero_next      = (shift_step == '0);
                    overflow_next  = 1'b0;
                    illegal_next   = 1'b0;
                    out_valid_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign out_valid  = out_valid_reg;
    assign result     = result_reg;
    assign zero       = zero_reg;
    assign overflow   = overflow_reg;
    assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal_op;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        in_valid    = 1'b1;
        alu_control = c;
        operand_a   = a;
        operand_b   = b;
        shamt       = sh;
    endtask

    // Single-cycle op with out_ready=1: result must appear at the accepting edge.
    task automatic run_single(input string tag, input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] sh,
                              input logic [31:0] er, input logic eo, input logic ei);
        out_ready = 1'b1;
        drive(c, a, b, sh);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, 32'(zero), 32'(er == 32'd0));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_ill"}, 32'(illegal_op), 32'(ei));
        $display("op %s ctrl=%b a=0x%08h b=0x%08h -> result=0x%08h z=%0d ov=%0d ill=%0d",
                 tag, c, a, b, result, zero, overflow, illegal_op);
        step();
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int hi;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_control = 4'd0;
        operand_a   = 32'd0;
        operand_b   = 32'd0;
        shamt       = 5'd0;
        out_ready   = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, zero, overflow, illegal_op}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single-cycle ops.
        run_single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1, 1'b0);
        run_single("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0, 1'b0);
        run_single("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1'b0);
        run_single("or", 4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F, 1'b0, 1'b0);
        run_single("xor", 4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0, 1'b0);
        run_single("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_single("slt_ovfcase", 4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1'b0);
        run_single("slt_false", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0, 1'b0);
        run_single("sll_sh0", 4'b1000, 32'hDEAD_BEEF, 32'h0000_0000, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_single("illegal4", 4'b0100, 32'h0000_0003, 32'h0000_0003, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
        run_single("illegalB", 4'b1011, 32'h0000_0005, 32'h0000_0000, 5'd3, 32'h0000_0000, 1'b0, 1'b1);

        // Back-to-back SUB then SLT, one per cycle.
        out_ready = 1'b1;
        drive(4'b0110, 32'd5, 32'd5, 5'd0);
        step();
        check("b2b_sub_result", result, 32'd0);
        check("b2b_sub_zero", 32'(zero), 32'd1);
        check("b2b_sub_in_ready", 32'(in_ready), 32'd1);
        $display("op b2b_sub result=0x%08h z=%0d", result, zero);
        drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
        step();
        in_valid = 1'b0;
        check("b2b_slt_valid", 32'(out_valid), 32'd1);
        check("b2b_slt_result", result, 32'd1);
        check("b2b_slt_zero", 32'(zero), 32'd0);
        $display("op b2b_slt result=0x%08h z=%0d", result, zero);
        step();

        // SRA by 31: in_ready low for 31 clocks, operand changes ignored.
        drive(4'b1010, 32'h8000_0000, 32'd0, 5'd31);
        step();
        in_valid  = 1'b0;
        operand_a = 32'h0000_0000;
        n = 0;
        hi = 0;
        while (!out_valid && n < 40) begin
            if (in_ready) hi++;
            step();
            n++;
        end
        check("sra_latency", 32'(n), 32'd31);
        check("sra_in_ready_low", 32'(hi), 32'd0);
        check("sra_result", result, 32'hFFFF_FFFF);
        check("sra_flags", {29'd0, zero, overflow, illegal_op}, 32'd0);
        $display("op sra31 latency=%0d result=0x%08h", n, result);
        step();

        // SLL by 4 with the consumer stalled.
        out_ready = 1'b0;
        drive(4'b1000, 32'd1, 32'd0, 5'd4);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("sll_latency", 32'(n), 32'd4);
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (result !== 32'h10 || !out_valid || in_ready) hi++;
            step();
        end
        check("sll_hold_errors", 32'(hi), 32'd0);
        check("sll_result", result, 32'h0000_0010);
        out_ready = 1'b1;
        #1;
        check("sll_in_ready_release", 32'(in_ready), 32'd1);
        $display("op sll4 latency=%0d result=0x%08h held", n, result);
        step();
        check("sll_consumed", 32'(out_valid), 32'd0);

        // SRL aborted by reset two clocks in.
        drive(4'b1001, 32'h0000_00F0, 32'd0, 5'd3);
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) hi++;
        end
        check("abort_no_output", 32'(hi), 32'd0);
        check("abort_idle", 32'(in_ready), 32'd1);
        $display("op srl3 aborted by reset, out_valid seen %0d times", hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
